// File: rtl/out_port_uart_pkg.sv
// Shared constants for the output-port UART: transmitter state encoding,
// default geometry and the line-level decode used by the tx register.
package out_port_uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int DEFAULT_DEPTH        = 4;
    localparam int DEFAULT_CLKS_PER_BIT = 4;

    // Serial line level driven while the transmitter sits in a given state.
    function automatic logic line_level(input logic [1:0] state, input logic data_bit);
        case (state)
            ST_START: return 1'b0;
            ST_DATA:  return data_bit;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/out_fifo.sv
// Synchronous FIFO feeding the UART transmitter. A push into a full FIFO is
// accepted only when a pop happens at the same edge; pops on empty are ignored.
module out_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [DATA_W-1:0]       i_data,
    output logic [DATA_W-1:0]       o_data,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_full,
    output logic                    o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              w_pop;
    logic              w_push;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];

    // When full, the slot being written is the one being read this edge;
    // the head is consumed from the pre-edge contents, so this is safe.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/out_port_uart.sv
// Output port with a small FIFO and an 8N1 serial transmitter. Bytes written
// with doOut are queued and shifted out LSB first on tx.
module out_port_uart
    import out_port_uart_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    doOut,
    input  logic [7:0]              dbus,
    output logic                    tx,
    output logic                    busy,
    output logic                    full,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int TW = $clog2(CLKS_PER_BIT);

    logic [1:0]    r_state;
    logic [TW-1:0] r_tick;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_overflow;

    logic [7:0]    w_fifo_data;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_drop;
    logic          w_tick_last;

    assign w_pop       = (r_state == ST_IDLE) && !w_empty;
    assign w_drop      = doOut && w_full && !w_pop;
    assign w_tick_last = (r_tick == TW'(CLKS_PER_BIT - 1));

    out_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (doOut),
        .i_pop   (w_pop),
        .i_data  (dbus),
        .o_data  (w_fifo_data),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // tx is registered from the pre-edge state, so the line trails the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tick     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_tx <= line_level(r_state, r_shift[0]);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_fifo_data;
                        r_state <= ST_START;
                        r_tick  <= '0;
                        r_bit   <= '0;
                    end
                end
                ST_START: begin
                    if (w_tick_last) begin
                        r_state <= ST_DATA;
                        r_tick  <= '0;
                        r_bit   <= '0;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_tick_last) begin
                        r_tick  <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= ST_STOP;
                            r_bit   <= '0;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_tick_last) begin
                        r_state <= ST_IDLE;
                        r_tick  <= '0;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx       = r_tx;
    assign busy     = (r_state != ST_IDLE) || !w_empty;
    assign full     = w_full;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_out_port_uart.sv
// Scoreboard bench for out_port_uart: stimulus queues expected bytes, a serial
// monitor decodes tx frames and pops/compares them independently.
module tb_out_port_uart;

    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       doOut;
    logic [7:0] dbus;
    logic       tx;
    logic       busy;
    logic       full;
    logic       overflow;
    logic [2:0] count;

    always #5 clk = ~clk;

    out_port_uart #(
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .doOut    (doOut),
        .dbus     (dbus),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .overflow (overflow),
        .count    (count)
    );

    int         n_chk    = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         n_frames = 0;
    int         cnt_peak = 0;
    int         m_state  = 0;
    int         m_cnt    = 0;
    logic       m_bad;
    logic [7:0] m_byte;
    logic [7:0] exp_q[$];
    int         starts[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end else begin
            n_pass++;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Serial receiver: one sample per clock on the falling edge.
    initial begin
        int slot;
        forever begin
            @(negedge clk);
            if (int'(count) > cnt_peak) cnt_peak = int'(count);
            if (reset === 1'b1) begin
                m_state = 0;
            end else if (m_state == 0) begin
                if (tx === 1'b0) begin
                    m_state = 1;
                    m_cnt   = 1;
                    m_bad   = 1'b0;
                    m_byte  = 8'h00;
                    starts.push_back(cyc);
                end
            end else begin
                slot = m_cnt / CPB;
                if (slot == 0) begin
                    if (tx !== 1'b0) m_bad = 1'b1;
                end else if (slot <= 8) begin
                    if (m_cnt % CPB == 0) m_byte[slot-1] = tx;
                    else if (tx !== m_byte[slot-1]) m_bad = 1'b1;
                end else begin
                    if (tx !== 1'b1) m_bad = 1'b1;
                end
                m_cnt++;
                if (m_cnt == FRAME) begin
                    m_state = 0;
                    n_frames++;
                    chk("frame_shape", int'(m_bad), 0);
                    chk("frame_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        chk("frame_byte", int'(m_byte), int'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic drive(input logic d, input logic [7:0] b, input logic r);
        doOut = d;
        dbus  = b;
        reset = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic wr(input logic [7:0] b, input logic expect_tx);
        if (expect_tx) exp_q.push_back(b);
        drive(1'b1, b, 1'b0);
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (!busy && exp_q.size() == 0 && m_state == 0) done = 1'b1;
            else idle(1);
        end
        chk("drain_timeout", int'(done), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int f0;
        doOut = 1'b0;
        dbus  = 8'h00;
        reset = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        chk("rst_tx", int'(tx), 1);
        chk("rst_count", int'(count), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_busy", int'(busy), 0);
        idle(2);

        // Single byte 0xA5: latency and busy window
        wr(8'hA5, 1'b1);
        chk("single_count", int'(count), 1);
        chk("single_busy_q", int'(busy), 1);
        idle(1);
        chk("single_tx_n1", int'(tx), 1);
        idle(1);
        chk("single_tx_n2", int'(tx), 0);
        idle(38);
        chk("single_busy_n40", int'(busy), 1);
        idle(2);
        chk("single_busy_n42", int'(busy), 0);
        chk("single_tx_idle", int'(tx), 1);
        drain();

        // Burst of three consecutive writes
        cnt_peak = 0;
        s0 = starts.size();
        wr(8'h01, 1'b1);
        wr(8'h02, 1'b1);
        wr(8'h03, 1'b1);
        drain();
        chk("burst_peak", cnt_peak, 2);
        chk("burst_frames", starts.size() - s0, 3);
        if (starts.size() >= s0 + 3) begin
            chk("burst_gap1", starts[s0+1] - starts[s0], FRAME + 1);
            chk("burst_gap2", starts[s0+2] - starts[s0+1], FRAME + 1);
        end

        // Overflow: sixth write into a full FIFO is dropped
        for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i), 1'b1);
        chk("ovf_count4", int'(count), 4);
        chk("ovf_full", int'(full), 1);
        chk("ovf_before", int'(overflow), 0);
        wr(8'h15, 1'b0);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count_hold", int'(count), 4);
        drain();
        chk("ovf_sticky", int'(overflow), 1);
        drive(1'b0, 8'h00, 1'b1);
        chk("ovf_cleared", int'(overflow), 0);
        chk("ovf_rst_count", int'(count), 0);

        // Full FIFO, write at the edge IDLE pops
        wr(8'h30, 1'b1);
        for (int i = 1; i < 5; i++) wr(8'h30 + 8'(i), 1'b1);
        idle(37);
        chk("fp_full_before", int'(full), 1);
        chk("fp_count_before", int'(count), 4);
        wr(8'h77, 1'b1);
        chk("fp_count_after", int'(count), 4);
        chk("fp_overflow", int'(overflow), 0);
        drain();

        // Reset during DATA bit 3 with two bytes queued
        s0 = starts.size();
        f0 = n_frames;
        wr(8'h40, 1'b0);
        wr(8'h41, 1'b0);
        wr(8'h42, 1'b0);
        chk("rmf_queued", int'(count), 2);
        idle(15);
        drive(1'b0, 8'h00, 1'b1);
        chk("rmf_tx", int'(tx), 1);
        chk("rmf_count", int'(count), 0);
        chk("rmf_busy", int'(busy), 0);
        idle(100);
        chk("rmf_no_frames", n_frames - f0, 0);
        chk("rmf_no_restart", starts.size() - s0, 1);
        chk("rmf_tx_idle", int'(tx), 1);

        // Reset wins over a simultaneous write
        s0 = starts.size();
        drive(1'b1, 8'h55, 1'b1);
        chk("rsw_count", int'(count), 0);
        chk("rsw_tx", int'(tx), 1);
        chk("rsw_busy", int'(busy), 0);
        idle(60);
        chk("rsw_no_frame", starts.size() - s0, 0);
        chk("rsw_tx_idle", int'(tx), 1);

        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/out_port_uart.md
OUT_PORT_UART -- requirements
Module: out_port_uart

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, meaning clk cycles per serial bit (>=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port doOut  input  1  write strobe, same control bit that loads qreg in the register stage.
REQ-006 SHALL have port dbus  input  8  data bus value written when doOut=1.
REQ-007 SHALL have port tx  output  1  serial line, idle high, registered.
REQ-008 SHALL have port busy  output  1  high when transmitter not IDLE or FIFO non-empty.
REQ-009 SHALL have port full  output  1  count==DEPTH.
REQ-010 SHALL have port overflow  output  1  sticky, set when a write is dropped.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-012 SHALL push dbus into the FIFO at a posedge where doOut=1 and the write is accepted.
REQ-013 SHALL accept a write when count<DEPTH, or when count==DEPTH and a pop occurs at the same edge.
REQ-014 SHALL drop a non-accepted write, leave FIFO contents unchanged, and set overflow=1 until reset.
REQ-015 SHALL keep FIFO order strictly first-in first-out, read/write pointers wrapping modulo DEPTH.
REQ-016 SHALL update count by +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-017 SHALL implement transmitter states IDLE, START, DATA, STOP.
REQ-018 IDLE: tx=1; at an edge where count>0, SHALL pop the head byte into an 8-bit shift register and enter START.
REQ-019 START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-020 DATA: SHALL emit bits 0..7 LSB first, each held CLKS_PER_BIT cycles, then STOP.
REQ-021 STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-022 SHALL use a bit-time counter 0..CLKS_PER_BIT-1 and a bit index 0..7, both cleared on each state entry.
REQ-023 Latency: doOut at edge n into an empty idle block -> pop at edge n+1 -> tx=0 from edge n+2.
REQ-024 Back-to-back frames SHALL be separated by exactly one IDLE cycle (tx=1); frame = 10*CLKS_PER_BIT cycles.
REQ-025 A write at the same edge the FIFO becomes empty via pop SHALL be accepted and transmitted next.
REQ-026 doOut held high for k cycles SHALL be treated as k independent writes.

Reset
REQ-027 On reset=1 at a posedge: state=IDLE, tx=1, pointers=0, count=0, full=0, overflow=0, busy=0, shift register=0.
REQ-028 Reset mid-frame SHALL abort the frame immediately and discard all FIFO contents; reset SHALL override a simultaneous doOut.

Structure
REQ-029 Transmitter state encoding and default DEPTH/CLKS_PER_BIT constants SHALL live in a shared package.
REQ-030 The FIFO SHALL be a sub-module named out_fifo (push, pop, data, count, full, empty).

Verification
REQ-031 Single byte: write 0xA5, CLKS_PER_BIT=4 -> tx low at edge n+2, bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high, busy falls after 40+2 cycles.
REQ-032 Burst: writes 0x01,0x02,0x03 on consecutive cycles -> three frames in order, one idle cycle between each, count peaks at 2.
REQ-033 Overflow: 6 consecutive writes 0x10..0x15, DEPTH=4 -> 0x10..0x14 transmitted (first popped immediately), 0x15 dropped, overflow=1 sticky.
REQ-034 Full with pop: FIFO full, write 0x77 at the edge IDLE pops -> accepted, count stays 4, overflow stays 0.
REQ-035 Reset mid-frame: reset during DATA bit 3 with 2 bytes queued -> next cycle tx=1, count=0, IDLE; no further frames.
REQ-036 Simultaneous reset and doOut with 0x55 -> nothing queued, tx stays 1.
